// File: rtl/me_search_ctl_if.sv
// Handshake/address bundle between the motion-estimation sequencer (master)
// and the frame-buffer / SAD datapath side (slave).
interface me_search_ctl_if #(
  parameter int AW  = 11,
  parameter int MVW = 4
) ();
  logic           start;
  logic           stall;
  logic           busy;
  logic           done;
  logic           rd_ref;
  logic [AW-1:0]  ref_x;
  logic [AW-1:0]  ref_y;
  logic           rd_srch;
  logic [AW-1:0]  srch_x;
  logic [AW-1:0]  srch_y;
  logic           compare;
  logic [MVW-1:0] mv_h;
  logic [MVW-1:0] mv_v;
  logic           blk_last;

  modport master (
    input  start, stall,
    output busy, done, rd_ref, ref_x, ref_y, rd_srch, srch_x, srch_y,
           compare, mv_h, mv_v, blk_last
  );

  modport slave (
    output start, stall,
    input  busy, done, rd_ref, ref_x, ref_y, rd_srch, srch_x, srch_y,
           compare, mv_h, mv_v, blk_last
  );
endinterface

// File: rtl/me_search_ctl.sv
// Full-search block-matching address/control sequencer (raster block walk).
// Define ME_HSEARCH_EN for 2-D search; otherwise vertical-only (no h counter).
module me_search_ctl #(
  parameter int FRAME_W = 1920,
  parameter int FRAME_H = 1080,
  parameter int BLK     = 4,
  parameter int SR      = 16,
  parameter int AW      = 11,
  parameter int MVW     = 4
) (
  input  logic            clk,
  input  logic            rst,
  me_search_ctl_if.master bus
);

  localparam int ROWS = BLK + SR - 1;
  localparam int RW   = $clog2(ROWS);

  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_CMP  = RW'(BLK - 1);
  localparam logic [AW-1:0] BLK_A    = AW'(BLK);
  localparam logic [AW-1:0] X_LAST   = AW'(FRAME_W - BLK);
  localparam logic [AW-1:0] Y_LAST   = AW'(FRAME_H - BLK);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [AW-1:0]  rx_q, rx_d;
  logic [AW-1:0]  ry_q, ry_d;
  logic [MVW-1:0] h_q;
  logic           h_last;

`ifdef ME_HSEARCH_EN
  logic [MVW-1:0] h_d;
  assign h_last = (h_q == MVW'(SR - 1));
`else
  assign h_q    = '0;
  assign h_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
`ifdef ME_HSEARCH_EN
      h_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
`ifdef ME_HSEARCH_EN
      h_q     <= h_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
`ifdef ME_HSEARCH_EN
    h_d     = h_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rx_d    = '0;
          ry_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!bus.stall) begin
          row_d   = '0;
`ifdef ME_HSEARCH_EN
          h_d     = '0;
`endif
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (!bus.stall) begin
          if (row_q == ROW_MAX) begin
            row_d = '0;
            if (h_last) begin
              // End of block: either the frame is finished or step raster-wise.
              if (rx_q == X_LAST && ry_q == Y_LAST) begin
                state_d = S_DONE;
              end else begin
                state_d = S_LOAD;
                if (rx_q == X_LAST) begin
                  rx_d = '0;
                  ry_d = ry_q + BLK_A;
                end else begin
                  rx_d = rx_q + BLK_A;
                end
              end
            end else begin
`ifdef ME_HSEARCH_EN
              h_d = h_q + 1'b1;
`endif
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic in_srch, srch_act, cmp_act;

  assign in_srch  = (state_q == S_SEARCH);
  assign srch_act = in_srch && !bus.stall;
  assign cmp_act  = srch_act && (row_q >= ROW_CMP);

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.rd_ref   = (state_q == S_LOAD) && !bus.stall;
  assign bus.ref_x    = rx_q;
  assign bus.ref_y    = ry_q;
  assign bus.rd_srch  = srch_act;
  // Addresses follow held state, so they stay stable through a stall.
  assign bus.srch_x   = in_srch ? rx_q + AW'(h_q)   : '0;
  assign bus.srch_y   = in_srch ? ry_q + AW'(row_q) : '0;
  assign bus.compare  = cmp_act;
  assign bus.mv_h     = cmp_act ? h_q : '0;
  assign bus.mv_v     = cmp_act ? MVW'(row_q - ROW_CMP) : '0;
  assign bus.blk_last = srch_act && (row_q == ROW_MAX) && h_last;

endmodule

// File: tb/tb_me_search_ctl.sv
// Scoreboard bench for me_search_ctl on a 16x8 frame (8 blocks, BLK=4, SR=16).
module tb_me_search_ctl;
  localparam int FW = 16, FH = 8, BLK = 4, SR = 16, AW = 11, MVW = 4;
`ifdef ME_HSEARCH_EN
  localparam int NH = SR;
`else
  localparam int NH = 1;
`endif
  localparam int ROWS = BLK + SR - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  me_search_ctl_if #(.AW(AW), .MVW(MVW)) bus ();

  me_search_ctl #(
    .FRAME_W(FW), .FRAME_H(FH), .BLK(BLK), .SR(SR), .AW(AW), .MVW(MVW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [57:0] v;
  } ev_t;
  ev_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [57:0] obs();
    return {bus.busy, bus.rd_ref, bus.rd_srch, bus.compare, bus.blk_last, bus.done,
            bus.ref_x, bus.ref_y, bus.srch_x, bus.srch_y, bus.mv_h, bus.mv_v};
  endfunction

  // Expected event list for a whole frame; events at or after st_at slip by st_len.
  task automatic build(input int st_at, input int st_len);
    int t;
    logic [AW-1:0] rx, ry, sx, sy;
    logic [MVW-1:0] mh, mv;
    logic cmp, last;
    ev_t e;
    q.delete();
    t = 1;
    for (int by = 0; by < FH / BLK; by++) begin
      for (int bx = 0; bx < FW / BLK; bx++) begin
        rx = AW'(bx * BLK);
        ry = AW'(by * BLK);
        e.t = (st_len > 0 && t >= st_at) ? t + st_len : t;
        e.v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rx, ry, {AW{1'b0}}, {AW{1'b0}},
               {MVW{1'b0}}, {MVW{1'b0}}};
        q.push_back(e);
        t++;
        for (int h = 0; h < NH; h++) begin
          for (int r = 0; r < ROWS; r++) begin
            sx   = rx + AW'(h);
            sy   = ry + AW'(r);
            cmp  = (r >= BLK - 1);
            last = (h == NH - 1) && (r == ROWS - 1);
            mh   = cmp ? MVW'(h) : '0;
            mv   = cmp ? MVW'(r - (BLK - 1)) : '0;
            e.t  = (st_len > 0 && t >= st_at) ? t + st_len : t;
            e.v  = {1'b1, 1'b0, 1'b1, cmp, last, 1'b0, rx, ry, sx, sy, mh, mv};
            q.push_back(e);
            t++;
          end
        end
      end
    end
    e.t = (st_len > 0 && t >= st_at) ? t + st_len : t;
    e.v = {1'b1, 5'b00001, AW'(FW - BLK), AW'(FH - BLK), {AW{1'b0}}, {AW{1'b0}},
           {MVW{1'b0}}, {MVW{1'b0}}};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && (bus.rd_ref || bus.rd_srch || bus.done)) begin
      if (q.size() == 0) begin
        chk("extra_event", 64'(obs()), 64'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_cycle", 64'(cyc - t0 + 1), 64'(e.t));
        chk("ev_outputs", 64'(obs()), 64'(e.v));
      end
    end
  end

  task automatic go();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0 = cyc;
    mon_en = 1'b1;
  endtask

  task automatic wait_rel(input int rel);
    int n = 0;
    while ((cyc - t0 + 1) < rel && n < 10000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic finish_run();
    int n = 0;
    while (q.size() > 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    chk("events_left", 64'(q.size()), 64'd0);
    repeat (5) @(negedge clk);
    chk("idle_after_done", 64'(obs()), {6'b0, AW'(FW - BLK), AW'(FH - BLK), 30'd0});
    mon_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle", 64'(obs()), 64'd0);
    end

    // Run 1: plain frame; a start pulse mid-frame must be ignored.
    @(posedge clk);
    #1;
    build(0, 0);
    go();
    wait_rel(50);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_run();

    // Reset mid-block discards everything.
    build(0, 0);
    go();
    wait_rel(100);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", 64'(obs()), 64'd0);
    q.delete();

    // Reset and start together: reset wins.
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_beats_start", 64'(obs()), 64'd0);

    // Run 2: fresh start at (0,0) with a 3-cycle stall at row 7 of block 0.
    @(posedge clk);
    #1;
    build(9, 3);
    go();
    wait_rel(9);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_strobes", 64'({bus.rd_ref, bus.rd_srch, bus.compare, bus.blk_last}), 64'd0);
      chk("stall_srch_y", 64'(bus.srch_y), 64'd7);
      chk("stall_mv", 64'({bus.mv_h, bus.mv_v}), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.stall = 1'b0;
    finish_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/me_search_ctl.md
# me_search_ctl

Parametrised address and control sequencer for full-search block-matching motion estimation. It walks the reference frame block by block in raster order. For each block it issues one reference-block read, then sweeps every candidate position in the padded search frame, emitting row addresses, a `compare` strobe and the candidate motion vector. It sits between the frame-buffer read ports and the SAD/compare datapath, and replaces the fixed 4x4, vertical-only controller of the previous generation.

## Interface
Parameters:
- `FRAME_W`, 1920: reference frame width in pixels; multiple of `BLK`.
- `FRAME_H`, 1080: reference frame height in pixels; multiple of `BLK`.
- `BLK`, 4: block edge in pixels, ≥2.
- `SR`, 16: candidate offsets per axis (0..SR-1); the search frame is padded by `SR` in x and y.
- `AW`, 11: address/coordinate width; must hold `FRAME_W+SR-1` and `FRAME_H+SR-1`.
- `MVW`, 4: motion-vector component width; must hold `SR-1`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `stall` in 1: freeze the sequencer for this cycle.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last candidate of the last block.
- `rd_ref` out 1: reference-block read strobe.
- `ref_x`, `ref_y` out AW: top-left of the current reference block.
- `rd_srch` out 1: search-frame row read strobe.
- `srch_x`, `srch_y` out AW: search-frame row address (leftmost pixel of the `BLK`-wide row).
- `compare` out 1: the datapath holds a complete candidate; evaluate it.
- `mv_h`, `mv_v` out MVW: candidate offset, valid while `compare`=1, 0 otherwise.
- `blk_last` out 1: high with the final `compare` of each block.

## Operation
- States: IDLE, LOAD, SEARCH, DONE. Internal counters: `h` (0..NH-1), `row` (0..BLK+SR-2), block position `ref_x`/`ref_y`.
- NH is `SR` when `ME_HSEARCH_EN` is defined, else 1.
- IDLE: all strobes low. On `start`=1, clear `ref_x`/`ref_y` and go to LOAD.
- LOAD (1 cycle): `rd_ref`=1. Clear `h` and `row`. Go to SEARCH.
- SEARCH: every cycle:
  - drive `rd_srch`=1, `srch_x`=`ref_x`+`h`, `srch_y`=`ref_y`+`row`;
  - drive `compare`=1 iff `row`≥`BLK`-1, with `mv_v`=`row`-(`BLK`-1) and `mv_h`=`h`;
  - `row` increments; at `BLK`+`SR`-2 it wraps to 0 and `h` increments.
- End of block: the cycle with `h`=NH-1 and `row`=`BLK`+`SR`-2 asserts `blk_last`.
  - If this is not the last block, advance the block position and go to LOAD. `ref_x`+=`BLK`; at `FRAME_W`-`BLK` it wraps to 0 and `ref_y`+=`BLK`.
  - If `ref_x`=`FRAME_W`-`BLK` and `ref_y`=`FRAME_H`-`BLK`, go to DONE.
- DONE (1 cycle): `done`=1, then IDLE.
- All outputs are decoded from registered state (Moore); no output depends combinationally on `start`.
- Coordinate arithmetic is unsigned AW-bit. Parameter legality is the integrator's responsibility; no run-time overflow checking.

## Timing
- Reset (`rst`=1 at a clock edge): state IDLE, all counters and coordinates 0, every output 0. This applies identically mid-frame; any partial block is discarded.
- `start` to first `rd_ref`: 1 cycle.
- Block period: 1 + NH·(`BLK`+`SR`-1) unstalled cycles.
  - Defaults: 305 cycles.
  - Without `ME_HSEARCH_EN`: 20 cycles.
- `compare` lags the first `rd_srch` of each column by `BLK`-1 cycles, and runs for `SR` cycles per column.
- `stall`=1 in LOAD or SEARCH:
  - `rd_ref`, `rd_srch`, `compare`, `blk_last` forced 0 that cycle;
  - all state held, and addresses stay stable;
  - on release, the sequence resumes with no skipped or repeated row.
- `stall` is ignored in IDLE and DONE; `done` is never stretched.
- `start` while `busy`=1 is ignored.
- `start` and `rst` in the same cycle: reset wins.

## Configuration
- `ME_HSEARCH_EN` defined: full 2-D search, NH=`SR`, and `mv_h` sweeps 0..SR-1.
- Not defined: vertical-only search, NH=1, `mv_h` tied to 0, and the `h` counter is removed. Port list is unchanged.

## Test plan
- Reset/idle: hold `rst` 3 cycles, release with `start`=0 -> all outputs 0, `busy`=0 for 10 cycles.
- Single-block sequence, defaults, `ME_HSEARCH_EN` on:
  - `start` -> `rd_ref` at cycle 1 with `ref_x`=`ref_y`=0;
  - first `compare` at cycle 5 with `mv_h`=0 and `mv_v`=0, at `srch_y`=3;
  - `blk_last` at cycle 305 with `mv_h`=15 and `mv_v`=15;
  - next `rd_ref` at cycle 306 with `ref_x`=4.
- Vertical-only build (macro off): 20-cycle block period; `mv_v` 0..15 on 16 consecutive `compare` cycles; `mv_h`=0 throughout.
- Stall: assert `stall` for 3 cycles at `row`=7 -> strobes low and `srch_y` frozen; resumes at `row`=7 and the block ends 3 cycles late.
- Frame wrap/done: `FRAME_W`=`FRAME_H`=8, `BLK`=4, `SR`=2 -> blocks at (0,0),(4,0),(0,4),(4,4); `done` pulses once; `start` during `busy` has no effect.
- Reset mid-block: `rst` during SEARCH -> IDLE next cycle, outputs 0; a fresh `start` restarts at (0,0).
